// File: rtl/pixel_coalescer_pkg.sv
// Shared constants and strobe helpers for the pixel write-combining stage.
package pixel_coalescer_pkg;

  localparam int unsigned DEF_HRES             = 1280;
  localparam int unsigned DEF_VRES             = 720;
  localparam int unsigned DEF_PIXEL_WIDTH      = 16;
  localparam int unsigned DEF_PIXELS_PER_CHUNK = 8;
  localparam int unsigned DEF_OUT_DEPTH        = 4;
  localparam int unsigned DEF_TIMEOUT          = 64;

  // Widest chunk strobe the helper can produce; callers truncate to their width.
  localparam int unsigned MAX_CHUNK_STRB_W = 256;

  // Place a per-pixel byte strobe at its lane position within a chunk strobe.
  function automatic logic [MAX_CHUNK_STRB_W-1:0] lane_strobe(
    input logic [31:0] strb,
    input int unsigned lane,
    input int unsigned bpp
  );
    logic [MAX_CHUNK_STRB_W-1:0] s;
    s = MAX_CHUNK_STRB_W'(strb);
    return s << (lane * bpp);
  endfunction

endpackage

// File: rtl/pixel_coalescer_fifo.sv
// Shift-register output FIFO: head entry is a flop, up to two pushes per cycle.
module chunk_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             push_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             ready_in,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CNT_W-1:0] free
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d, base;
  logic             pop;

  // Shift out the head on pop, then append push_a followed by push_b.
  always_comb begin
    pop   = (cnt_q != '0) && ready_in;
    base  = cnt_q - CNT_W'(pop);
    mem_d = mem_q;
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) mem_d[i] = mem_q[i+1];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push_a && (32'(base) == i)) mem_d[i] = data_a;
      if (push_b && (32'(base) + 32'd1 == i)) mem_d[i] = data_b;
    end
    cnt_d = base + CNT_W'(push_a) + CNT_W'(push_b);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[0];
  assign valid = (cnt_q != '0);
  assign free  = CNT_W'(DEPTH) - cnt_q;

endmodule

// File: rtl/pixel_coalescer.sv
// Write-combining stage: merges pixel writes into aligned strobed chunks.
module pixel_coalescer
  import pixel_coalescer_pkg::*;
#(
  parameter int unsigned HRES             = DEF_HRES,
  parameter int unsigned VRES             = DEF_VRES,
  parameter int unsigned PIXEL_WIDTH      = DEF_PIXEL_WIDTH,
  parameter int unsigned PIXELS_PER_CHUNK = DEF_PIXELS_PER_CHUNK,
  parameter int unsigned OUT_DEPTH        = DEF_OUT_DEPTH,
  parameter int unsigned TIMEOUT          = DEF_TIMEOUT,
  localparam int unsigned ADDR_W = $clog2(HRES * VRES),
  localparam int unsigned LANE_W = $clog2(PIXELS_PER_CHUNK),
  localparam int unsigned TAG_W  = ADDR_W - LANE_W,
  localparam int unsigned BPP    = PIXEL_WIDTH / 8,
  localparam int unsigned DATA_W = PIXELS_PER_CHUNK * PIXEL_WIDTH,
  localparam int unsigned STRB_W = PIXELS_PER_CHUNK * BPP
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [ADDR_W-1:0]      addr_in,
  input  logic [PIXEL_WIDTH-1:0] data_in,
  input  logic [BPP-1:0]         strobe_in,
  input  logic                   last_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic                   flush_in,
  output logic [TAG_W-1:0]       chunk_addr_out,
  output logic [DATA_W-1:0]      data_out,
  output logic [STRB_W-1:0]      strobe_out,
  output logic                   last_out,
  output logic                   valid_out,
  input  logic                   ready_in
);

  localparam int unsigned ENTRY_W = 1 + TAG_W + STRB_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(OUT_DEPTH + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 2);

  logic               open_q, open_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [STRB_W-1:0]  strb_q, strb_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               flush_pend_q, flush_pend_d;

  logic [LANE_W-1:0]  lane;
  logic [TAG_W-1:0]   tag_in;
  logic [STRB_W-1:0]  lane_strb;
  logic [DATA_W-1:0]  pix_rep;
  logic               accept, wr_px, mismatch, last_close;
  logic               m_open;
  logic [TAG_W-1:0]   m_tag;
  logic [DATA_W-1:0]  m_data;
  logic [STRB_W-1:0]  m_strb;
  logic               timeout_hit, close_want, close_ok;
  logic [31:0]        avail;
  logic               push_a, push_b;
  logic [ENTRY_W-1:0] entry_a, entry_b, fifo_dout;
  logic [CNT_W-1:0]   free_slots;
  logic               fifo_valid;

  // Two free slots cover the worst case: evict on mismatch plus an immediate close.
  assign ready_out = (free_slots >= CNT_W'(2));
  assign pix_rep   = {PIXELS_PER_CHUNK{data_in}};

  always_comb begin
    lane      = addr_in[LANE_W-1:0];
    tag_in    = addr_in[ADDR_W-1:LANE_W];
    lane_strb = STRB_W'(lane_strobe(32'(strobe_in), 32'(lane), BPP));
    accept    = valid_in && ready_out;
    wr_px     = accept && (|strobe_in);
    mismatch  = wr_px && open_q && (tag_in != tag_q);
    last_close = accept && last_in;

    m_open = open_q;
    m_tag  = tag_q;
    m_data = data_q;
    m_strb = strb_q;
    if (wr_px) begin
      if (!open_q || mismatch) begin
        m_data = '0;
        m_strb = '0;
      end
      m_open = 1'b1;
      m_tag  = tag_in;
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (lane_strb[b]) m_data[b*8 +: 8] = pix_rep[b*8 +: 8];
      end
      m_strb = m_strb | lane_strb;
    end

    // Idle count lags the edge count by one, so fire when the next edge reaches TIMEOUT.
    timeout_hit = (TIMEOUT != 0) && open_q && !accept &&
                  ((32'(idle_q) + 32'd1) >= 32'(TIMEOUT));
    close_want  = m_open && ((&m_strb) || last_close || flush_in || flush_pend_q || timeout_hit);
    avail       = 32'(free_slots) + 32'(fifo_valid && ready_in);
    close_ok    = close_want && (avail >= (mismatch ? 32'd2 : 32'd1));

    push_a  = mismatch || close_ok;
    push_b  = mismatch && close_ok;
    entry_b = {last_close, m_tag, m_strb, m_data};
    entry_a = mismatch ? {1'b0, tag_q, strb_q, data_q} : entry_b;

    open_d = m_open && !close_ok;
    tag_d  = close_ok ? '0 : m_tag;
    data_d = close_ok ? '0 : m_data;
    strb_d = close_ok ? '0 : m_strb;

    idle_d = idle_q;
    if (accept || close_ok) idle_d = '0;
    else if (open_q && (idle_q != IDLE_W'(TIMEOUT))) idle_d = idle_q + IDLE_W'(1);

    flush_pend_d = (flush_in || flush_pend_q) && m_open && !close_ok;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      open_q       <= 1'b0;
      tag_q        <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      idle_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      open_q       <= open_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      idle_q       <= idle_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  chunk_out_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .push_a  (push_a),
    .data_a  (entry_a),
    .push_b  (push_b),
    .data_b  (entry_b),
    .ready_in(ready_in),
    .dout    (fifo_dout),
    .valid   (fifo_valid),
    .free    (free_slots)
  );

  assign {last_out, chunk_addr_out, strobe_out, data_out} = fifo_dout;
  assign valid_out = fifo_valid;

endmodule

// File: tb/tb_pixel_coalescer.sv
// Randomised and directed bench for pixel_coalescer against a queue-based chunk model.
module tb_pixel_coalescer;

  localparam int unsigned HRES = 1280, VRES = 720, PW = 16, PPC = 8, DEPTH = 4, TO = 64;
  localparam int unsigned ADDR_W = $clog2(HRES * VRES);
  localparam int unsigned LANE_W = $clog2(PPC);
  localparam int unsigned TAG_W  = ADDR_W - LANE_W;
  localparam int unsigned BPP    = PW / 8;
  localparam int unsigned NB     = PPC * BPP;
  localparam int unsigned DW     = PPC * PW;

  logic              clk_in, rst_n_in, rst2_n;
  logic [ADDR_W-1:0] addr_in;
  logic [PW-1:0]     data_in;
  logic [BPP-1:0]    strobe_in;
  logic              last_in, valid_in, flush_in, ready_in;
  logic              ready_out, last_out, valid_out;
  logic [TAG_W-1:0]  chunk_addr_out;
  logic [DW-1:0]     data_out;
  logic [NB-1:0]     strobe_out;
  logic              r2_ready_out, r2_last_out, r2_valid_out;
  logic [TAG_W-1:0]  r2_chunk_addr_out;
  logic [DW-1:0]     r2_data_out;
  logic [NB-1:0]     r2_strobe_out;

  pixel_coalescer #(.TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .addr_in(addr_in), .data_in(data_in),
    .strobe_in(strobe_in), .last_in(last_in), .valid_in(valid_in), .ready_out(ready_out),
    .flush_in(flush_in), .chunk_addr_out(chunk_addr_out), .data_out(data_out),
    .strobe_out(strobe_out), .last_out(last_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  pixel_coalescer #(.TIMEOUT(0)) dut_no_to (
    .clk_in(clk_in), .rst_n_in(rst2_n), .addr_in(addr_in), .data_in(data_in),
    .strobe_in(strobe_in), .last_in(last_in), .valid_in(valid_in), .ready_out(r2_ready_out),
    .flush_in(flush_in), .chunk_addr_out(r2_chunk_addr_out), .data_out(r2_data_out),
    .strobe_out(r2_strobe_out), .last_out(r2_last_out), .valid_out(r2_valid_out), .ready_in(1'b1)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int unsigned   tag;
    logic [DW-1:0] data;
    logic [NB-1:0] strb;
    bit            last;
  } ent_t;

  ent_t        mq[$];
  bit          m_open, m_fp;
  int unsigned m_tag, m_edge, m_last_act;
  logic [7:0]  m_byte [NB];
  bit          m_stb [NB];
  int          checks = 0;
  int          errors = 0;

  function automatic ent_t pack_open(input bit lst);
    ent_t e;
    e.tag = m_tag; e.last = lst; e.data = '0; e.strb = '0;
    for (int i = 0; i < NB; i++) begin
      e.data[i*8 +: 8] = m_byte[i];
      e.strb[i]        = m_stb[i];
    end
    return e;
  endfunction

  task automatic model_clear_chunk();
    m_open = 0;
    for (int i = 0; i < NB; i++) begin m_byte[i] = '0; m_stb[i] = 0; end
  endtask

  task automatic model_reset();
    mq.delete();
    model_clear_chunk();
    m_fp = 0; m_tag = 0; m_edge = 0; m_last_act = 0;
  endtask

  // Reference behaviour for one clock edge, from the inputs presented before it.
  task automatic model_step();
    int unsigned free, avail, tag, lane;
    bit rdy, pop, acc, wr, mis, all_set, want;
    m_edge++;
    free  = DEPTH - mq.size();
    rdy   = (free >= 2);
    pop   = (mq.size() != 0) && ready_in;
    avail = free + (pop ? 1 : 0);
    acc   = valid_in && rdy;
    wr    = acc && (strobe_in != '0);
    tag   = addr_in / PPC;
    lane  = addr_in % PPC;
    mis   = wr && m_open && (tag != m_tag);
    if (acc) m_last_act = m_edge;
    if (mis) begin mq.push_back(pack_open(0)); model_clear_chunk(); end
    if (wr) begin
      m_open = 1; m_tag = tag;
      for (int b = 0; b < BPP; b++)
        if (strobe_in[b]) begin m_byte[lane*BPP+b] = data_in[b*8 +: 8]; m_stb[lane*BPP+b] = 1; end
    end
    all_set = 1;
    for (int i = 0; i < NB; i++) if (!m_stb[i]) all_set = 0;
    want = m_open && (all_set || (acc && last_in) || flush_in || m_fp ||
                      (TO != 0 && !acc && (m_edge - m_last_act) >= TO));
    if (want && avail >= (mis ? 2 : 1)) begin
      mq.push_back(pack_open(acc && last_in));
      model_clear_chunk();
      m_last_act = m_edge;
      m_fp = 0;
    end else begin
      m_fp = m_open && (m_fp || flush_in);
    end
    if (pop) void'(mq.pop_front());
  endtask

  always @(posedge clk_in) if (rst_n_in) model_step();

  // Every-cycle comparison of the DUT outputs against the model queue head.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      checks++;
      if (valid_out !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL valid_out t=%0t: got %0b expected %0b", $time, valid_out, mq.size() != 0);
      end
      checks++;
      if (ready_out !== (mq.size() + 2 <= DEPTH)) begin
        errors++;
        $display("FAIL ready_out t=%0t: got %0b expected %0b", $time, ready_out, mq.size() + 2 <= DEPTH);
      end
      if (mq.size() != 0) begin
        checks++;
        if (chunk_addr_out !== TAG_W'(mq[0].tag) || data_out !== mq[0].data ||
            strobe_out !== mq[0].strb || last_out !== mq[0].last) begin
          errors++;
          $display("FAIL chunk_out t=%0t: got tag %0h data %h strb %h last %0b, expected tag %0h data %h strb %h last %0b",
                   $time, chunk_addr_out, data_out, strobe_out, last_out,
                   mq[0].tag, mq[0].data, mq[0].strb, mq[0].last);
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, DW'(valid_out), DW'(0));
    check({name, "_ready"}, DW'(ready_out), DW'(1));
    check({name, "_last"},  DW'(last_out), DW'(0));
    check({name, "_tag"},   DW'(chunk_addr_out), DW'(0));
    check({name, "_data"},  data_out, DW'(0));
    check({name, "_strb"},  DW'(strobe_out), DW'(0));
  endtask

  task automatic send(input int unsigned a, input logic [PW-1:0] d, input logic [BPP-1:0] s, input bit l);
    int unsigned w = 0;
    while (!ready_out && w < 500) begin @(negedge clk_in); w++; end
    if (!ready_out) check("send_ready_wait", DW'(ready_out), DW'(1));
    addr_in = ADDR_W'(a); data_in = d; strobe_in = s; last_in = l; valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_flush();
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
  endtask

  task automatic drain();
    ready_in = 1'b1;
    for (int w = 0; w < 200 && mq.size() != 0; w++) @(negedge clk_in);
    check("drain_empty", DW'(mq.size()), DW'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp;
    int            first;
    bit            seen2;
    int unsigned   base;

    model_reset();
    rst_n_in = 1'b0; rst2_n = 1'b0;
    addr_in = '0; data_in = '0; strobe_in = '0; last_in = 0; valid_in = 0; flush_in = 0; ready_in = 1;
    #1 check_reset_outputs("reset0");
    idle(2);
    rst_n_in = 1'b1;
    idle(1);

    // Sequential fill of chunk 0 closes on full strobe.
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("fill_not_yet", DW'(valid_out), DW'(0));
      send(i, PW'(16'h1000 + i), 2'b11, 0);
      exp[i*PW +: PW] = PW'(16'h1000 + i);
    end
    check("fill_valid", DW'(valid_out), DW'(1));
    check("fill_tag", DW'(chunk_addr_out), DW'(0));
    check("fill_strb", DW'(strobe_out), DW'(16'hFFFF));
    check("fill_data", data_out, exp);
    idle(2);

    // Byte merge with override, then eviction by a new chunk.
    send(5, 16'hAAAA, 2'b01, 0);
    send(5, 16'hBBBB, 2'b10, 0);
    send(16, 16'h1234, 2'b11, 0);
    exp = '0; exp[5*PW +: PW] = 16'hBBAA;
    check("merge_valid", DW'(valid_out), DW'(1));
    check("merge_tag", DW'(chunk_addr_out), DW'(0));
    check("merge_strb", DW'(strobe_out), DW'(16'h0C00));
    check("merge_data", data_out, exp);
    idle(2);
    check("chunk2_open", DW'(valid_out), DW'(0));
    do_flush();
    check("flush_tag", DW'(chunk_addr_out), DW'(2));
    check("flush_strb", DW'(strobe_out), DW'(16'h0003));
    idle(2);

    // Mismatch together with last_in pushes two chunks on one edge.
    ready_in = 1'b0;
    send(0, 16'h0101, 2'b11, 0);
    send(8, 16'h0808, 2'b11, 1);
    check("lm_first_tag", DW'(chunk_addr_out), DW'(0));
    check("lm_first_last", DW'(last_out), DW'(0));
    ready_in = 1'b1;
    @(negedge clk_in);
    check("lm_second_tag", DW'(chunk_addr_out), DW'(1));
    check("lm_second_last", DW'(last_out), DW'(1));
    check("lm_second_strb", DW'(strobe_out), DW'(16'h0003));
    @(negedge clk_in);
    check("lm_empty", DW'(valid_out), DW'(0));

    // Backpressure with 20 distinct chunks.
    ready_in = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(i * 8 + (i % 8), PW'(16'h5000 + i), 2'b11, 0);
      end
      begin
        idle(30);
        check("bp_ready_low", DW'(ready_out), DW'(0));
        check("bp_head_tag", DW'(chunk_addr_out), DW'(0));
        ready_in = 1'b1;
      end
    join
    do_flush();
    drain();

    // Idle timeout; the TIMEOUT=0 instance must keep its chunk open.
    rst2_n = 1'b1;
    idle(1);
    send(9, 16'hC0DE, 2'b11, 0);
    first = -1; seen2 = 0;
    for (int j = 1; j <= int'(TO) + 20; j++) begin
      @(negedge clk_in);
      if (r2_valid_out) seen2 = 1;
      if (valid_out && first < 0) begin
        first = j;
        exp = '0; exp[1*PW +: PW] = 16'hC0DE;
        check("to_tag", DW'(chunk_addr_out), DW'(1));
        check("to_strb", DW'(strobe_out), DW'(16'h000C));
        check("to_data", data_out, exp);
      end
    end
    check("to_latency", DW'(first), DW'(TO));
    check("to0_never", DW'(seen2), DW'(0));
    do_flush();
    check("to0_flush_valid", DW'(r2_valid_out), DW'(1));
    check("to0_flush_tag", DW'(r2_chunk_addr_out), DW'(1));
    rst2_n = 1'b0;
    idle(2);

    // Randomised traffic.
    base = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 63) == 0) base = $urandom_range(0, 2000) * 8;
      valid_in  = ($urandom_range(0, 3) != 0);
      addr_in   = ADDR_W'(base + $urandom_range(0, 23));
      data_in   = PW'($urandom);
      strobe_in = BPP'($urandom);
      last_in   = ($urandom_range(0, 39) == 0);
      flush_in  = ($urandom_range(0, 19) == 0);
      ready_in  = ($urandom_range(0, 3) != 0);
      @(negedge clk_in);
    end
    valid_in = 0; last_in = 0; flush_in = 0;
    do_flush();
    drain();

    // Asynchronous reset mid-stream discards FIFO and open chunk.
    ready_in = 1'b0;
    send(800, 16'h1111, 2'b11, 0);
    send(808, 16'h2222, 2'b11, 0);
    send(816, 16'h3333, 2'b11, 0);
    check("pre_reset_valid", DW'(valid_out), DW'(1));
    #2 rst_n_in = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    ready_in = 1'b1;
    idle(3);
    check("post_reset_empty", DW'(valid_out), DW'(0));
    for (int i = 0; i < 8; i++) send(24 + i, PW'($urandom), 2'b11, 0);
    check("post_reset_tag", DW'(chunk_addr_out), DW'(3));
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_coalescer.md
# pixel_coalescer

Parametrised write-combining stage between the rasterizer and the framebuffer write port. It packs per-pixel writes into aligned multi-pixel chunks with per-byte strobes, merging repeated writes to the same chunk. Chunks are closed on address change, full coverage, end-of-frame, explicit flush or idle timeout. A small output FIFO decouples it from downstream stalls.

## Interface
Parameters:
- HRES, 1280, horizontal resolution in pixels
- VRES, 720, vertical resolution in pixels
- PIXEL_WIDTH, 16, bits per pixel; multiple of 8
- PIXELS_PER_CHUNK, 8, pixels per chunk; power of two, ≥2
- OUT_DEPTH, 4, output FIFO entries; ≥2
- TIMEOUT, 64, idle cycles before an open chunk is auto-closed; 0 disables
- Derived: ADDR_W=$clog2(HRES*VRES), LANE_W=$clog2(PIXELS_PER_CHUNK), TAG_W=ADDR_W-LANE_W, BPP=PIXEL_WIDTH/8

Ports:
- clk_in  in  1  sole clock
- rst_n_in  in  1  asynchronous, active-low reset
- addr_in  in  ADDR_W  linear pixel address
- data_in  in  PIXEL_WIDTH  pixel data
- strobe_in  in  BPP  per-byte write enable
- last_in  in  1  final pixel of frame
- valid_in  in  1  input valid
- ready_out  out  1  input ready
- flush_in  in  1  single-cycle request to close the open chunk
- chunk_addr_out  out  TAG_W  chunk index (addr_in>>LANE_W)
- data_out  out  PIXELS_PER_CHUNK*PIXEL_WIDTH  lane i at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH]
- strobe_out  out  PIXELS_PER_CHUNK*BPP  byte enables, lane-ordered like data_out
- last_out  out  1  chunk was closed by last_in
- valid_out  out  1  output valid
- ready_in  in  1  downstream ready

## Operation
- State: one open-chunk register holding tag, data, strobe and open flag; an idle counter; a flush_pending flag; the output FIFO.
- Accept occurs when valid_in && ready_out. Lane is addr_in[LANE_W-1:0]; tag is addr_in[ADDR_W-1:LANE_W].
- Accept with strobe_in==0: pixel discarded, no state change except idle counter reset.
- Accept, chunk not open: open with the tag. Lane bytes are written where strobe is set; all other strobes are 0.
- Accept, tag matches: merge per byte. Strobed bytes overwrite (last write wins). Strobe is ORed.
- Accept, tag mismatch: push the old chunk to the FIFO, then open the new one with the pixel.
- Close conditions, checked after the merge in the same cycle:
  - strobe all ones
  - last_in accepted (last_out=1)
  - flush_in or flush_pending
  - idle counter == TIMEOUT (TIMEOUT≠0)
- Close pushes the chunk to the FIFO and clears the open flag, data and strobe.
- A close needing a FIFO slot when none is free is deferred until a slot frees. flush_in is latched into flush_pending and cleared by the close. Flush with no open chunk is a no-op.
- ready_out = FIFO free slots ≥ 2. This uses the registered count, with no combinational path from ready_in. An accept needs at most 2 slots (mismatch plus immediate close).
- Idle counter: cleared on accept or close; otherwise increments while open, saturating at TIMEOUT.
- The FIFO pops on valid_out && ready_in. A push and a pop in the same cycle are allowed when full.

## Timing
- Reset values: valid_out=0, last_out=0, chunk_addr_out=0, data_out=0, strobe_out=0, ready_out=1, FIFO empty, chunk closed, counters 0.
- Reset asserted mid-operation discards the open chunk and all FIFO contents.
- Latency: a chunk closed at edge N is presented with valid_out=1 in cycle N+1, output fields registered.
- Output fields are stable while valid_out && !ready_in.
- Timeout: the last accept is at edge N; the close is at edge N+TIMEOUT if a slot is free.
- Simultaneous events:
  - accept plus timeout: the accept wins and the counter clears.
  - accept plus flush_in: the pixel is merged, then the chunk containing it is closed.
  - mismatch plus last_in: two pushes in the same edge.
- Throughput: one pixel per cycle while ready_in=1 and OUT_DEPTH≥4.

## Structure
- Package pixel_coalescer_pkg holds the default parameter constants and a function that expands a BPP strobe into a lane-positioned chunk strobe.
- Sub-module chunk_out_fifo (parameters WIDTH, DEPTH): registered-output synchronous FIFO with free-slot count. It accepts up to 2 pushes per cycle.

## Test plan
- Reset: assert rst_n_in asynchronously mid-stream → all outputs at reset values immediately, ready_out=1.
- Sequential fill: addresses 0–7, strobe 2'b11 → one chunk, chunk_addr_out=0, strobe_out=16'hFFFF, valid_out the cycle after the 8th accept.
- Merge/override: addr 5 data 16'hAAAA strobe 2'b01, then addr 5 data 16'hBBBB strobe 2'b10, then addr 16 → chunk 0 with lane5=16'hBBAA, strobe_out=16'h0C00; chunk 2 stays open.
- Backpressure: ready_in=0 with 20 pixels in 20 distinct chunks → ready_out drops when free slots<2; no chunk lost, order preserved after release.
- Timeout: single pixel at addr 9, then idle → chunk 1 with lane1 valid, valid_out exactly TIMEOUT+1 cycles after the accept; with TIMEOUT=0 it never closes.
- last_in plus mismatch: open chunk 0, then accept addr 8 with last_in → two chunks, and the second has last_out=1.
